// File: rtl/vc_pad_ctrl.sv
// vc_pad_ctrl: pad interface and reset generator for a small core.
// - Bidirectional pads are driven from registered data and enable bits.
// - Pad values are synchronised before they reach the core.
// - Switch inputs are synchronised and then debounced per channel.
// - The core reset is held until the clock generator reports a stable lock.
//
// Reset generator states
//   state | meaning
//   HOLD  | lock not seen; core held in reset; stretch counter cleared
//   COUNT | lock seen; stretch counter running; core still held in reset
//   RUN   | core released (core_rst_n = 1)
module vc_pad_ctrl #(
  parameter int WIDTH       = 8,
  parameter int NIN         = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_BITS     = 4,
  parameter int RST_STRETCH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             locked,
  input  logic [NIN-1:0]   ui_in,
  output logic [NIN-1:0]   ui_db,
  inout  wire  [WIDTH-1:0] uio_io,
  input  logic [WIDTH-1:0] core_uio_out,
  input  logic [WIDTH-1:0] core_uio_oe,
  output logic [WIDTH-1:0] core_uio_in,
  output logic             core_rst_n
);

  localparam int CNT_W = $clog2(RST_STRETCH + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(RST_STRETCH - 1);
  localparam logic [DB_BITS-1:0] DB_LAST  = '1;

  typedef enum logic [1:0] {HOLD, COUNT, RUN} state_t;

  logic [SYNC_STAGES-1:0] r_lk_sync;
  logic [NIN-1:0]         r_ui_sync  [SYNC_STAGES];
  logic [WIDTH-1:0]       r_pad_sync [SYNC_STAGES];
  logic [DB_BITS-1:0]     r_db_cnt   [NIN];
  logic [NIN-1:0]         r_db;
  logic [WIDTH-1:0]       r_out;
  logic [WIDTH-1:0]       r_oe;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_core_rst_n;
  state_t                 r_state;

  state_t                 w_next;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   w_lk;
  logic [NIN-1:0]         w_s;

  assign w_lk        = r_lk_sync[SYNC_STAGES-1];
  assign w_s         = r_ui_sync[SYNC_STAGES-1];
  assign core_uio_in = r_pad_sync[SYNC_STAGES-1];
  assign ui_db       = r_db;
  assign core_rst_n  = r_core_rst_n;

  // Synchronise lock, switch inputs and pad values into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lk_sync <= '0;
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_ui_sync[k]  <= '0;
        r_pad_sync[k] <= '0;
      end
    end else begin
      r_lk_sync    <= {r_lk_sync[SYNC_STAGES-2:0], locked};
      r_ui_sync[0]  <= ui_in;
      r_pad_sync[0] <= uio_io;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_ui_sync[k]  <= r_ui_sync[k-1];
        r_pad_sync[k] <= r_pad_sync[k-1];
      end
    end
  end

  // Per-channel debounce: a disagreement must persist for a full window to be accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db <= '0;
      for (int i = 0; i < NIN; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (w_s[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db[i]     <= w_s[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Reset generator next-state and stretch counter; any loss of lock restarts from HOLD.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      HOLD: begin
        w_cnt_next = '0;
        if (w_lk) w_next = COUNT;
      end
      COUNT: begin
        if (!w_lk) begin
          w_next     = HOLD;
          w_cnt_next = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_next = RUN;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!w_lk) begin
          w_next     = HOLD;
          w_cnt_next = '0;
        end
      end
      default: begin
        w_next     = HOLD;
        w_cnt_next = '0;
      end
    endcase
  end

  // State register; core_rst_n follows the state being entered so release lands on a clk edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= HOLD;
      r_cnt        <= '0;
      r_core_rst_n <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_cnt_next;
      r_core_rst_n <= (w_next == RUN);
    end
  end

  // Pad output registers; enables are cleared on exactly the edges that hold the core in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= '0;
      r_oe  <= '0;
    end else begin
      r_out <= core_uio_out;
      r_oe  <= (w_next == RUN) ? core_uio_oe : '0;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_pad
    assign uio_io[g] = r_oe[g] ? r_out[g] : 1'bz;
  end

endmodule

// File: tb/tb_vc_pad_ctrl.sv
// Directed bench for vc_pad_ctrl at default parameters.
// The bench drives every pad the DUT is expected to leave floating, so a DUT that
// drives when it should not shows up as a wrong pad value.
module tb_vc_pad_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       locked;
  logic [7:0] ui_in;
  logic [7:0] ui_db;
  logic [7:0] core_uio_out;
  logic [7:0] core_uio_oe;
  logic [7:0] core_uio_in;
  logic       core_rst_n;
  wire  [7:0] pad;
  logic [7:0] tb_en;
  logic [7:0] tb_val;

  int total = 0;
  int bad   = 0;

  vc_pad_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .locked       (locked),
    .ui_in        (ui_in),
    .ui_db        (ui_db),
    .uio_io       (pad),
    .core_uio_out (core_uio_out),
    .core_uio_oe  (core_uio_oe),
    .core_uio_in  (core_uio_in),
    .core_rst_n   (core_rst_n)
  );

  for (genvar g = 0; g < 8; g++) begin : g_tbdrv
    assign pad[g] = tb_en[g] ? tb_val[g] : 1'bz;
  end

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset        = 1'b1;
    locked       = 1'b1;
    ui_in        = 8'h00;
    core_uio_out = 8'hFF;
    core_uio_oe  = 8'hFF;
    tb_en        = 8'hFF;
    tb_val       = 8'h00;
    #2;
    chk("rst_core_rst_n", {7'b0, core_rst_n}, 8'h00);
    chk("rst_ui_db", ui_db, 8'h00);
    chk("rst_core_uio_in", core_uio_in, 8'h00);
    chk("rst_pad_hiz", pad, 8'h00);
    ticks(3);
    reset = 1'b0;

    // release sequence: core_rst_n rises on the 19th edge
    ticks(10);
    chk("seq10_rst_n", {7'b0, core_rst_n}, 8'h00);
    chk("seq10_pad_hiz", pad, 8'h00);
    ticks(8);
    chk("seq18_rst_n", {7'b0, core_rst_n}, 8'h00);
    chk("seq18_pad_hiz", pad, 8'h00);
    core_uio_oe = 8'h00;
    tick();
    chk("seq19_rst_n", {7'b0, core_rst_n}, 8'h01);

    // pad output path: 1 cycle to pad, 2 more to core_uio_in
    tb_en        = 8'hF0;
    tb_val       = 8'hC0;
    core_uio_oe  = 8'h0F;
    core_uio_out = 8'hA5;
    tick();
    chk("pad_drive", pad, 8'hC5);
    ticks(2);
    chk("pad_loopback", core_uio_in, 8'hC5);

    // clean edge on bit 3
    ui_in = 8'h08;
    ticks(17);
    chk("db3_before", ui_db, 8'h00);
    tick();
    chk("db3_after", ui_db, 8'h08);

    // 10-cycle glitch on bit 0
    ui_in = 8'h09;
    ticks(10);
    ui_in = 8'h08;
    ticks(25);
    chk("db0_glitch10", ui_db, 8'h08);

    // 15-cycle pulse on bit 1: one short of the window
    ui_in = 8'h0A;
    ticks(15);
    ui_in = 8'h08;
    ticks(25);
    chk("db1_pulse15", ui_db, 8'h08);

    // 16-cycle pulse on bit 2: just long enough, then falls back
    ui_in = 8'h0C;
    ticks(16);
    ui_in = 8'h08;
    ticks(2);
    chk("db2_pulse16_rise", ui_db, 8'h0C);
    ticks(15);
    chk("db2_pulse16_hold", ui_db, 8'h0C);
    tick();
    chk("db2_pulse16_fall", ui_db, 8'h08);

    // simultaneous edges on bits 5 and 6
    ui_in = 8'h68;
    ticks(17);
    chk("db56_before", ui_db, 8'h08);
    tick();
    chk("db56_after", ui_db, 8'h68);

    // one-cycle lock drop while running
    locked = 1'b0;
    tick();
    locked = 1'b1;
    tick();
    chk("lk_drop_e2", {7'b0, core_rst_n}, 8'h01);
    tick();
    chk("lk_drop_e3", {7'b0, core_rst_n}, 8'h00);
    tb_en  = 8'hFF;
    tb_val = 8'hCA;
    #1;
    chk("lk_drop_pad_hiz", pad, 8'hCA);
    ticks(16);
    chk("lk_rerise_before", {7'b0, core_rst_n}, 8'h00);
    tb_en  = 8'hF0;
    tb_val = 8'hC0;
    tick();
    chk("lk_rerise", {7'b0, core_rst_n}, 8'h01);
    chk("lk_rerise_pad", pad, 8'hC5);

    // reset pulse mid-COUNT between clock edges
    locked = 1'b0;
    ticks(4);
    tb_en  = 8'hFF;
    tb_val = 8'h00;
    locked = 1'b1;
    ticks(8);
    chk("count_rst_n", {7'b0, core_rst_n}, 8'h00);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_n", {7'b0, core_rst_n}, 8'h00);
    chk("async_ui_db", ui_db, 8'h00);
    reset = 1'b0;
    ticks(17);
    chk("rerun17_ui_db", ui_db, 8'h00);
    tick();
    chk("rerun18_rst_n", {7'b0, core_rst_n}, 8'h00);
    chk("rerun18_ui_db", ui_db, 8'h68);
    chk("rerun18_pad_hiz", pad, 8'h00);
    tick();
    chk("rerun19_rst_n", {7'b0, core_rst_n}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
